fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
Controller that sequences a full coefficient reload of the symmetric FIR through its c_WE/c_in/c_addr port. It accepts a valid/ready coefficient stream from the host side and writes words to consecutive FIR addresses. It holds the FIR in load mode, which freezes its sample counters, for the whole transfer plus a drain tail. It verifies a modular checksum and reports done, error and a timeout abort.

Parameters:
ORD, 256, FIR order; the number of coefficients is NC = (ORD+1)>>1 = 128.
COEFF_SIZE, 16, coefficient width in bits.
AW, $clog2((ORD+1)>>1) = 7, FIR coefficient address width.
TIMEOUT, 1023, maximum idle cycles between accepted beats in FILL before abort.
TAIL, 2, cycles c_WE stays high after the last write so the FIR's internal write pipeline completes.

Ports:
clk  in  1  clock
nrst  in  1  reset
start  in  1  one-cycle request to begin a reload; ignored unless in IDLE
abort  in  1  synchronous cancel; returns to IDLE
exp_sum  in  COEFF_SIZE  expected modulo-2^COEFF_SIZE sum of all NC words; sampled on accepted start
s_valid  in  1  stream word valid
s_data  in  COEFF_SIZE  stream coefficient, raw bits
s_ready  out  1  loader accepts a word this cycle
c_WE  out  1  FIR coefficient write enable / load mode
c_in  out  COEFF_SIZE  coefficient to FIR
c_addr  out  AW  FIR coefficient address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of a reload, whether good or failed
err_code  out  2  00 ok, 01 timeout, 10 checksum mismatch; valid with done, held until next accepted start
sum  out  COEFF_SIZE  running modular sum of accepted words

Behaviour:
- Reset is asynchronous and active-low on nrst; the clock is clk.
- Reset values: state IDLE, s_ready=0, c_WE=0, c_in=0, c_addr=0, busy=0, done=0, err_code=00, sum=0, index=0, timer=0.
- All outputs are registered. Beat acceptance is s_valid && s_ready.
- States: IDLE, FILL, TAILW, CHECK.
- IDLE: s_ready=0 and c_WE=0.
  - start -> FILL.
  - On that transition: latch exp_sum, clear sum, index and timer, and clear err_code.
- FILL: s_ready=1.
  - On each accepted beat, the next cycle shows c_in=s_data, c_addr=index and c_WE=1; sum += s_data (mod 2^COEFF_SIZE); index++; timer=0.
  - c_WE stays 0 until the first beat. This prevents a garbage write to address 0.
  - After the first beat, c_WE stays 1 continuously. During gaps c_in/c_addr hold their values, so rewrites are idempotent.
  - No beat in a cycle: timer++.
  - timer reaches TIMEOUT -> err_code=01, drop c_WE, pulse done -> IDLE.
  - A beat accepted with index==NC-1 -> s_ready=0 the following cycle -> TAILW. No beat beyond NC is accepted.
- TAILW: c_WE held at 1 with the last c_in/c_addr for TAIL cycles -> CHECK.
- CHECK: one cycle.
  - c_WE=0 and done=1.
  - err_code = 10 if sum != latched exp_sum, else 00.
  - -> IDLE.
- Write throughput is one coefficient per clk. The minimum reload time from start to done is 1 + NC + TAIL + 1 cycles.
- abort in any non-IDLE state: next cycle c_WE=0, s_ready=0, -> IDLE, no done pulse, err_code unchanged.
  - abort has priority over beat acceptance, timeout and CHECK in the same cycle.
- start while busy is ignored and does not affect exp_sum.
- Reset mid-operation: everything returns to its reset values immediately. A partial coefficient set may remain in the FIR, and the host must reload.
- sum wraps silently at 2^COEFF_SIZE.
- Address wrap cannot occur because index is bounded by NC-1.

Test Plan:
- Reset, start with exp_sum = sum of 3k for k=0..127 (mod 2^16 = 24384), stream words 3k back-to-back.
  -> c_addr steps 0..127 on 128 consecutive cycles with c_in=3k and c_WE=1 throughout.
  -> c_WE high 2 extra cycles, then done pulse with err_code=00 and sum=24384.
- Same load with s_valid toggling 1-of-3 cycles.
  -> same address/data sequence with holds during gaps; c_WE never drops mid-load; err_code=00.
- Load with exp_sum deliberately off by 1.
  -> all 128 writes occur, then done with err_code=10.
- Stream stops after 50 words.
  -> after 1023 idle cycles c_WE falls, done pulses, err_code=01, busy=0.
- start asserted mid-FILL, then abort at word 20.
  -> second start has no effect; one cycle after abort c_WE=0, s_ready=0, busy=0, and no done pulse.
- nrst pulsed low at word 64, then a fresh full load.
  -> outputs take reset values asynchronously; the new load completes with err_code=00.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
// Sequences a full coefficient reload of the symmetric FIR through its
// c_WE/c_in/c_addr write port. Words arrive on a valid/ready stream and are
// written to consecutive FIR addresses. c_WE doubles as the FIR's load-mode
// flag, so it is held high from the first write through a short drain tail.
// A modular checksum of the accepted words is compared against the expected
// value that was sampled on start.
//
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   start       one-cycle reload request (only honoured when idle)
//   abort       synchronous cancel back to idle, no done pulse
//   exp_sum     expected modulo-2^COEFF_SIZE sum, sampled on accepted start
//   s_valid     stream word valid
//   s_data      stream coefficient
//   s_ready     loader accepts a word this cycle
//   c_WE        FIR coefficient write enable / load mode
//   c_in        coefficient to FIR
//   c_addr      FIR coefficient address
//   busy        high whenever not idle
//   done        one-cycle pulse at the end of a reload (good or failed)
//   err_code    00 ok, 01 timeout, 10 checksum mismatch; held until next start
//   sum         running modular sum of accepted words
module fir_coeff_loader #(
  parameter int ORD        = 256,
  parameter int COEFF_SIZE = 16,
  parameter int AW         = $clog2((ORD + 1) >> 1),
  parameter int TIMEOUT    = 1023,
  parameter int TAIL       = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [COEFF_SIZE-1:0] exp_sum,
  input  logic                  s_valid,
  input  logic [COEFF_SIZE-1:0] s_data,
  output logic                  s_ready,
  output logic                  c_WE,
  output logic [COEFF_SIZE-1:0] c_in,
  output logic [AW-1:0]         c_addr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [COEFF_SIZE-1:0] sum
);

  localparam int NC  = (ORD + 1) >> 1;
  localparam int TMW = $clog2(TIMEOUT + 1);
  localparam int TLW = (TAIL < 1) ? 1 : $clog2(TAIL + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_TAILW = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic                  s_ready_q,  s_ready_d;
  logic                  c_we_q,     c_we_d;
  logic [COEFF_SIZE-1:0] c_in_q,     c_in_d;
  logic [AW-1:0]         c_addr_q,   c_addr_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [COEFF_SIZE-1:0] sum_q,      sum_d;
  logic [COEFF_SIZE-1:0] exp_q,      exp_d;
  logic [AW-1:0]         index_q,    index_d;
  logic [TMW-1:0]        timer_q,    timer_d;
  logic [TLW-1:0]        tail_q,     tail_d;

  logic beat;

  assign beat = s_valid && s_ready_q;

  always_comb begin
    state_d    = state_q;
    s_ready_d  = s_ready_q;
    c_we_d     = c_we_q;
    c_in_d     = c_in_q;
    c_addr_d   = c_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_code_d = err_code_q;
    sum_d      = sum_q;
    exp_d      = exp_q;
    index_d    = index_q;
    timer_d    = timer_q;
    tail_d     = tail_q;

    // abort wins over everything else that could happen this cycle
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      s_ready_d = 1'b0;
      c_we_d    = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_FILL;
            s_ready_d  = 1'b1;
            busy_d     = 1'b1;
            exp_d      = exp_sum;
            sum_d      = '0;
            index_d    = '0;
            timer_d    = '0;
            err_code_d = 2'b00;
          end
        end
        ST_FILL: begin
          if (beat) begin
            // c_WE stays high through gaps; c_in/c_addr hold, so the FIR
            // just rewrites the same word
            c_in_d   = s_data;
            c_addr_d = index_q;
            c_we_d   = 1'b1;
            sum_d    = sum_q + s_data;
            timer_d  = '0;
            if (index_q == AW'(NC - 1)) begin
              s_ready_d = 1'b0;
              state_d   = ST_TAILW;
              tail_d    = '0;
            end else begin
              index_d = index_q + 1'b1;
            end
          end else if (timer_q == TMW'(TIMEOUT - 1)) begin
            timer_d    = timer_q + 1'b1;
            err_code_d = 2'b01;
            c_we_d     = 1'b0;
            s_ready_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_TAILW: begin
          // the cycle showing the last write is followed by TAIL more
          // cycles of c_WE before load mode is released
          if (tail_q == TLW'(TAIL)) begin
            state_d    = ST_CHECK;
            c_we_d     = 1'b0;
            done_d     = 1'b1;
            err_code_d = (sum_q != exp_q) ? 2'b10 : 2'b00;
          end else begin
            tail_d = tail_q + 1'b1;
          end
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          s_ready_d = 1'b0;
          c_we_d    = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      s_ready_q  <= 1'b0;
      c_we_q     <= 1'b0;
      c_in_q     <= '0;
      c_addr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_code_q <= 2'b00;
      sum_q      <= '0;
      exp_q      <= '0;
      index_q    <= '0;
      timer_q    <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      c_we_q     <= c_we_d;
      c_in_q     <= c_in_d;
      c_addr_q   <= c_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_code_q <= err_code_d;
      sum_q      <= sum_d;
      exp_q      <= exp_d;
      index_q    <= index_d;
      timer_q    <= timer_d;
      tail_q     <= tail_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign c_WE     = c_we_q;
  assign c_in     = c_in_q;
  assign c_addr   = c_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_code = err_code_q;
  assign sum      = sum_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader
// Self-checking bench for fir_coeff_loader. Stream words are 3*k for
// address k; each accepted beat pushes its expected write onto a queue,
// which is popped and compared when the write shows up on the FIR port.
module tb_fir_coeff_loader;

  localparam int CW = 16;
  localparam int AW = 7;
  localparam int NC = 128;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic          abort;
  logic [CW-1:0] exp_sum;
  logic          s_valid;
  logic [CW-1:0] s_data;
  logic          s_ready;
  logic          c_WE;
  logic [CW-1:0] c_in;
  logic [AW-1:0] c_addr;
  logic          busy;
  logic          done;
  logic [1:0]    err_code;
  logic [CW-1:0] sum;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [AW+CW-1:0] exp_q[$];
  logic [AW+CW-1:0] last_wr;
  logic [CW-1:0]    model_sum;

  fir_coeff_loader dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .abort    (abort),
    .exp_sum  (exp_sum),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .c_WE     (c_WE),
    .c_in     (c_in),
    .c_addr   (c_addr),
    .busy     (busy),
    .done     (done),
    .err_code (err_code),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  // Drives a start pulse at the current negedge and checks the FILL entry state.
  task automatic begin_load(input logic [CW-1:0] e);
    start = 1'b1;
    exp_sum = e;
    model_sum = '0;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if ({busy, s_ready, c_WE, err_code, sum} !== {1'b1, 1'b1, 1'b0, 2'b00, 16'h0})
      $display("[TB] FAIL fill_entry: got busy/rdy/we/err/sum=%b want 1/1/0/00/0", {busy, s_ready, c_WE, err_code, sum});
    else pass_cnt++;
  endtask

  // Streams words first..first+n-1 with s_valid high every 'period' cycles.
  // Returns at the negedge after the last write was checked.
  task automatic stream_words(input int first, input int n, input int period,
                              input bit we_on, output int cycles);
    bit pending = 1'b0;
    bit started = we_on;
    int sent = 0;
    int cyc = 0;
    logic [AW+CW-1:0] e;
    while ((sent < n || pending) && cyc < 5000) begin
      if (pending) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if ({c_WE, c_addr, c_in} !== {1'b1, e})
          $display("[TB] FAIL write: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                   c_WE, c_addr, c_in, e[AW+CW-1:CW], e[CW-1:0]);
        else pass_cnt++;
        chk_cnt++;
        if (sum !== model_sum) $display("[TB] FAIL run_sum: got %0d want %0d", sum, model_sum);
        else pass_cnt++;
        last_wr = e;
        pending = 1'b0;
        started = 1'b1;
      end else if (started) begin
        chk_cnt++;
        if ({c_WE, c_addr, c_in} !== {1'b1, last_wr})
          $display("[TB] FAIL gap_hold: got we=%b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                   c_WE, c_addr, c_in, last_wr[AW+CW-1:CW], last_wr[CW-1:0]);
        else pass_cnt++;
      end else begin
        chk_cnt++;
        if (c_WE !== 1'b0) $display("[TB] FAIL pre_write_we: got %b want 0", c_WE);
        else pass_cnt++;
      end
      s_valid = (sent < n) && (cyc % period == 0);
      s_data = CW'(3 * (first + sent));
      if (s_valid && s_ready) begin
        exp_q.push_back({AW'(first + sent), s_data});
        model_sum = model_sum + s_data;
        pending = 1'b1;
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk_cnt++;
    if (sent != n) $display("[TB] FAIL stream_budget: got %0d words want %0d", sent, n);
    else pass_cnt++;
    cycles = cyc;
  endtask

  // Called one cycle after the last write: checks the drain tail and the done pulse.
  task automatic finish_load(input logic [1:0] want_err);
    chk_cnt++;
    if ({c_WE, s_ready, c_addr, done} !== {1'b1, 1'b0, 7'd127, 1'b0})
      $display("[TB] FAIL tail1: got we/rdy/addr/done=%b want 1/0/127/0", {c_WE, s_ready, c_addr, done});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({c_WE, done} !== 2'b10) $display("[TB] FAIL tail2: got we/done=%b want 10", {c_WE, done});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({done, c_WE, busy, err_code} !== {1'b1, 1'b0, 1'b1, want_err})
      $display("[TB] FAIL done_pulse: got done/we/busy/err=%b want 101%b", {done, c_WE, busy, err_code}, want_err);
    else pass_cnt++;
    chk_cnt++;
    if (sum !== model_sum) $display("[TB] FAIL final_sum: got %0d want %0d", sum, model_sum);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({done, busy, err_code} !== {1'b0, 1'b0, want_err})
      $display("[TB] FAIL after_done: got done/busy/err=%b want 00%b", {done, busy, err_code}, want_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    exp_sum = '0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({s_ready, c_WE, c_in, c_addr, busy, done, err_code, sum} !== '0)
      $display("[TB] FAIL reset_values: got %h want 0", {s_ready, c_WE, c_in, c_addr, busy, done, err_code, sum});
    else pass_cnt++;
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({s_ready, c_WE, busy, done} !== 4'b0000)
      $display("[TB] FAIL idle_after_reset: got %b want 0000", {s_ready, c_WE, busy, done});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    begin_load(16'd24384);
    stream_words(0, NC, 1, 1'b0, cyc);
    chk_cnt++;
    if (cyc != NC + 1) $display("[TB] FAIL consecutive: got %0d cycles want %0d", cyc, NC + 1);
    else pass_cnt++;
    finish_load(2'b00);
  endtask

  task automatic test_gapped();
    int cyc;
    begin_load(16'd24384);
    stream_words(0, NC, 3, 1'b0, cyc);
    finish_load(2'b00);
  endtask

  task automatic test_checksum();
    int cyc;
    begin_load(16'd24385);
    stream_words(0, NC, 1, 1'b0, cyc);
    finish_load(2'b10);
  endtask

  task automatic test_timeout();
    int cyc;
    int w;
    begin_load(16'd24384);
    stream_words(0, 50, 1, 1'b0, cyc);
    chk_cnt++;
    if ({c_WE, done} !== 2'b10) $display("[TB] FAIL idle_we: got we/done=%b want 10", {c_WE, done});
    else pass_cnt++;
    w = 1;
    while (done !== 1'b1 && w < 1100) begin
      @(negedge clk);
      w++;
    end
    chk_cnt++;
    if (w != 1023) $display("[TB] FAIL timeout_delay: got %0d idle cycles want 1023", w);
    else pass_cnt++;
    chk_cnt++;
    if ({done, c_WE, busy, s_ready, err_code} !== 6'b100001)
      $display("[TB] FAIL timeout_state: got done/we/busy/rdy/err=%b want 100001", {done, c_WE, busy, s_ready, err_code});
    else pass_cnt++;
    chk_cnt++;
    if (sum !== model_sum) $display("[TB] FAIL timeout_sum: got %0d want %0d", sum, model_sum);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({done, err_code} !== 3'b001) $display("[TB] FAIL timeout_hold: got done/err=%b want 001", {done, err_code});
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int cyc;
    begin_load(16'd24384);
    stream_words(0, 10, 1, 1'b0, cyc);
    start = 1'b1;
    exp_sum = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if ({busy, s_ready, sum} !== {1'b1, 1'b1, model_sum})
      $display("[TB] FAIL busy_start: got busy/rdy/sum=%h want %h", {busy, s_ready, sum}, {1'b1, 1'b1, model_sum});
    else pass_cnt++;
    stream_words(10, 10, 1, 1'b1, cyc);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_cnt++;
    if ({c_WE, s_ready, busy, done, err_code} !== 6'b000000)
      $display("[TB] FAIL abort_state: got we/rdy/busy/done/err=%b want 000000", {c_WE, s_ready, busy, done, err_code});
    else pass_cnt++;
    repeat (4) begin
      @(negedge clk);
      chk_cnt++;
      if ({done, busy} !== 2'b00) $display("[TB] FAIL abort_no_done: got done/busy=%b want 00", {done, busy});
      else pass_cnt++;
    end
    chk_cnt++;
    if (sum !== 16'd570) $display("[TB] FAIL abort_sum: got %0d want 570", sum);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    begin_load(16'd24384);
    stream_words(0, 64, 1, 1'b0, cyc);
    #2 nrst = 1'b0;
    #1;
    chk_cnt++;
    if ({s_ready, c_WE, c_in, c_addr, busy, done, err_code, sum} !== '0)
      $display("[TB] FAIL async_reset: got %h want 0", {s_ready, c_WE, c_in, c_addr, busy, done, err_code, sum});
    else pass_cnt++;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    test_back_to_back();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_checksum();
    test_timeout();
    test_abort();
    test_reset_mid();
    chk_cnt++;
    if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
